// File: rtl/dispense_step_sequencer_if.sv
// Pi-side command/acknowledge bundle plus the stepper driver pins of the
// dispense step sequencer. The master is the command source (the Pi GPIO
// side, or a testbench). The slave is the sequencer itself.
interface dispense_step_sequencer_if;
  logic [2:0] teststate;
  logic [1:0] stateamount;
  logic       candyflag;
  logic       signalrecieved;
  logic       stepperstep;
  logic       stepperdir;
  logic       busy;
  logic       done;

  modport master (
    output teststate, stateamount, candyflag,
    input  signalrecieved, stepperstep, stepperdir, busy, done
  );

  modport slave (
    input  teststate, stateamount, candyflag,
    output signalrecieved, stepperstep, stepperdir, busy, done
  );
endinterface

// File: rtl/dispense_step_sequencer.sv
// Dispense step sequencer.
// Turns a Pi dispense command (slot, amount, go flag) into a bounded burst of
// stepper step/dir pulses and acknowledges the command back to the Pi.
// Every Pi input is asynchronous to clk_x1, so each one is double-flopped
// before use. Once a burst starts it always runs to completion.
module dispense_step_sequencer #(
  parameter int STEP_DIV       = 3000,
  parameter int STEPS_PER_UNIT = 200,
  parameter int DIR_SETUP      = 120
) (
  input  logic                       clk_x1,
  input  logic                       rst,
  dispense_step_sequencer_if.slave   bus
);

  localparam int TIMER_MAX = (STEP_DIV > DIR_SETUP) ? STEP_DIV : DIR_SETUP;
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam int SW        = $clog2(4 * STEPS_PER_UNIT + 1);

  localparam logic [TW-1:0] SETUP_LOAD = TW'(DIR_SETUP - 1);
  localparam logic [TW-1:0] DIV_LOAD   = TW'(STEP_DIV - 1);
  localparam logic [SW-1:0] SPU        = SW'(STEPS_PER_UNIT);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SETUP,
    STEP_HI,
    STEP_LO,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;

  logic [2:0]      r_tsMeta, r_tsSync;
  logic [1:0]      r_amtMeta, r_amtSync;
  logic            r_cfMeta, r_cfSync, r_cfPrev;

  logic [2:0]      r_lastState;
  logic [2:0]      r_slot;
  logic [2:0]      r_units;
  logic [TW-1:0]   r_timer, w_timerNext;
  logic [SW-1:0]   r_stepsLeft, w_stepsNext, w_stepsDec;

  logic            r_ack, r_busy, r_done, r_step, r_dir;
  logic            w_tsZero, w_trigger, w_cfRise, w_latch, w_fire;

  assign w_tsZero   = (r_tsSync == 3'd0);
  assign w_trigger  = !w_tsZero && (r_tsSync != r_lastState);
  assign w_cfRise   = r_cfSync & ~r_cfPrev;
  assign w_stepsDec = r_stepsLeft - SW'(1);

  // Two-flop synchronizers for the Pi inputs, plus a delayed candyflag copy for edge detection
  always_ff @(posedge clk_x1 or posedge rst) begin
    if (rst) begin
      r_tsMeta  <= '0;
      r_tsSync  <= '0;
      r_amtMeta <= '0;
      r_amtSync <= '0;
      r_cfMeta  <= 1'b0;
      r_cfSync  <= 1'b0;
      r_cfPrev  <= 1'b0;
    end else begin
      r_tsMeta  <= bus.teststate;
      r_tsSync  <= r_tsMeta;
      r_amtMeta <= bus.stateamount;
      r_amtSync <= r_amtMeta;
      r_cfMeta  <= bus.candyflag;
      r_cfSync  <= r_cfMeta;
      r_cfPrev  <= r_cfSync;
    end
  end

  // Next-state logic: command latch, arming, direction setup, then HI/LO step phases
  always_comb begin
    w_stateNext = r_state;
    w_timerNext = r_timer;
    w_stepsNext = r_stepsLeft;
    w_latch     = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_stateNext = ARMED;
          w_latch     = 1'b1;
        end
      end
      ARMED: begin
        if (w_tsZero) begin
          w_stateNext = IDLE;
        end else if (w_cfRise) begin
          w_stateNext = SETUP;
          w_fire      = 1'b1;
          w_timerNext = SETUP_LOAD;
          w_stepsNext = SW'(r_units) * SPU;
        end
      end
      SETUP: begin
        if (r_timer == '0) begin
          w_stateNext = STEP_HI;
          w_timerNext = DIV_LOAD;
        end else begin
          w_timerNext = r_timer - TW'(1);
        end
      end
      STEP_HI: begin
        if (r_timer == '0) begin
          w_stateNext = STEP_LO;
          w_timerNext = DIV_LOAD;
        end else begin
          w_timerNext = r_timer - TW'(1);
        end
      end
      STEP_LO: begin
        if (r_timer == '0) begin
          w_stepsNext = w_stepsDec;
          if (w_stepsDec == '0) begin
            w_stateNext = DONE;
          end else begin
            w_stateNext = STEP_HI;
            w_timerNext = DIV_LOAD;
          end
        end else begin
          w_timerNext = r_timer - TW'(1);
        end
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // State, phase timer and remaining-step counter registers
  always_ff @(posedge clk_x1 or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_stepsLeft <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_timer     <= w_timerNext;
      r_stepsLeft <= w_stepsNext;
    end
  end

  // Command latch; last_state blocks a held slot from retriggering until the Pi returns to 0
  always_ff @(posedge clk_x1 or posedge rst) begin
    if (rst) begin
      r_slot      <= '0;
      r_units     <= '0;
      r_lastState <= '0;
    end else begin
      if (w_latch) begin
        r_slot  <= r_tsSync;
        r_units <= {1'b0, r_amtSync} + 3'd1;
      end
      if (w_tsZero) begin
        r_lastState <= '0;
      end else if (w_latch) begin
        r_lastState <= r_tsSync;
      end
    end
  end

  // Registered outputs decoded from the next state so they change glitch-free with the state
  always_ff @(posedge clk_x1 or posedge rst) begin
    if (rst) begin
      r_ack  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_step <= 1'b0;
      r_dir  <= 1'b0;
    end else begin
      r_ack  <= (w_stateNext != IDLE);
      r_busy <= (w_stateNext != IDLE);
      r_done <= (w_stateNext == DONE);
      r_step <= (w_stateNext == STEP_HI);
      if (w_fire) begin
        r_dir <= (r_slot <= 3'd3);
      end
    end
  end

  assign bus.signalrecieved = r_ack;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.stepperstep    = r_step;
  assign bus.stepperdir     = r_dir;

endmodule

// File: tb/tb_dispense_step_sequencer.sv
// Testbench for dispense_step_sequencer.
// A table of directed commands runs first, followed by randomized commands.
// Hand-written sequences then cover the flag-already-high and mid-burst
// reset corners. A free-running monitor measures pulse counts and widths
// and records the cycle of the first rise and of the done pulse. Every
// command is scored against expectations derived from the command itself.
module tb_dispense_step_sequencer;

  localparam int STEP_DIV       = 2;
  localparam int STEPS_PER_UNIT = 3;
  localparam int DIR_SETUP      = 4;
  localparam int CMD_LAT        = 3;
  localparam int MAX_BURST      = CMD_LAT + DIR_SETUP + 4 * STEPS_PER_UNIT * 2 * STEP_DIV;

  typedef struct {
    logic [2:0] slot;
    logic [1:0] amt;
    bit         zeroFirst;
    bit         cancel;
    bit         disturb;
    bit         expTrig;
    int         expPulses;
    bit         expDir;
  } vec_t;

  logic clk_x1;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  int   cyc          = 0;
  int   rises        = 0;
  int   dones        = 0;
  int   widthErr     = 0;
  int   firstRiseCyc = 0;
  int   doneCyc      = 0;
  int   burstPulses  = 0;
  int   lastRiseCyc  = 0;
  int   lastFallCyc  = 0;
  logic prevStep     = 1'b0;

  logic [2:0] modelLast = 3'd0;
  vec_t       vecs[8];

  dispense_step_sequencer_if bus ();

  dispense_step_sequencer #(
    .STEP_DIV      (STEP_DIV),
    .STEPS_PER_UNIT(STEPS_PER_UNIT),
    .DIR_SETUP     (DIR_SETUP)
  ) dut (
    .clk_x1(clk_x1),
    .rst   (rst),
    .bus   (bus)
  );

  // 100 MHz-style free-running clock; the period itself is irrelevant to the design
  initial clk_x1 = 1'b0;
  always #5 clk_x1 = ~clk_x1;

  // Monitor: counts step pulses and done pulses and flags any HI or LO phase that is not STEP_DIV long
  always @(posedge clk_x1) begin
    #1;
    cyc = cyc + 1;
    if (rst) begin
      burstPulses = 0;
    end else begin
      if (bus.stepperstep && !prevStep) begin
        rises = rises + 1;
        if (burstPulses == 0) firstRiseCyc = cyc;
        else if (cyc - lastFallCyc != STEP_DIV) widthErr = widthErr + 1;
        burstPulses = burstPulses + 1;
        lastRiseCyc = cyc;
      end
      if (!bus.stepperstep && prevStep) begin
        if (cyc - lastRiseCyc != STEP_DIV) widthErr = widthErr + 1;
        lastFallCyc = cyc;
      end
      if (bus.done) begin
        if (burstPulses > 0 && cyc - lastFallCyc != STEP_DIV) widthErr = widthErr + 1;
        dones       = dones + 1;
        doneCyc     = cyc;
        burstPulses = 0;
      end
    end
    prevStep = bus.stepperstep;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_x1);
  endtask

  // Present a slot/amount and check that the acknowledge follows the trigger rule
  task automatic armCommand(input logic [2:0] slot, input logic [1:0] amt, input bit zeroFirst,
                            input bit expTrig, input string tag);
    if (zeroFirst) begin
      bus.teststate = 3'd0;
      waitCycles(4);
    end
    bus.teststate   = slot;
    bus.stateamount = amt;
    waitCycles(4);
    checkOutput({tag, "/ack"}, bus.signalrecieved, expTrig);
    checkOutput({tag, "/busyArmed"}, bus.busy, expTrig);
  endtask

  // Drop teststate and raise candyflag together: the cancel must win, with no burst
  task automatic cancelCommand(input string tag);
    int r0;
    int d0;
    r0 = rises;
    d0 = dones;
    bus.teststate = 3'd0;
    bus.candyflag = 1'b1;
    waitCycles(20);
    checkOutput({tag, "/ackCancel"}, bus.signalrecieved, 0);
    checkOutput({tag, "/pulsesCancel"}, rises - r0, 0);
    checkOutput({tag, "/doneCancel"}, dones - d0, 0);
    bus.candyflag = 1'b0;
    waitCycles(3);
  endtask

  // Raise candyflag and score the resulting burst (or its absence)
  task automatic fireAndCheck(input logic [2:0] slot, input bit expTrig, input int expPulses,
                              input bit expDir, input bit disturb, input string tag);
    int         r0;
    int         d0;
    int         w0;
    int         c0;
    int         waited;
    logic [2:0] otherSlot;
    otherSlot = 3'((int'(slot) % 7) + 1);
    r0 = rises;
    d0 = dones;
    w0 = widthErr;
    c0 = cyc;
    bus.candyflag = 1'b1;
    if (expTrig) begin
      waited = 0;
      while (dones == d0 && waited < MAX_BURST + 20) begin
        waitCycles(1);
        waited = waited + 1;
        if (disturb) begin
          if (waited >= 2 && waited < 10) begin
            bus.candyflag   = waited[0];
            bus.stateamount = 2'($urandom);
            if (waited == 4) bus.teststate = otherSlot;
          end
          if (waited == 10) begin
            bus.teststate = slot;
            bus.candyflag = 1'b1;
          end
        end
      end
      checkOutput({tag, "/doneCount"}, dones - d0, 1);
      checkOutput({tag, "/firstRise"}, firstRiseCyc - c0, CMD_LAT + DIR_SETUP);
      checkOutput({tag, "/doneAt"}, doneCyc - c0, CMD_LAT + DIR_SETUP + expPulses * 2 * STEP_DIV);
      checkOutput({tag, "/dir"}, bus.stepperdir, expDir);
      waitCycles(2);
      checkOutput({tag, "/busyAfter"}, bus.busy, 0);
    end else begin
      waitCycles(MAX_BURST + 4);
      checkOutput({tag, "/noDone"}, dones - d0, 0);
    end
    checkOutput({tag, "/ackAfter"}, bus.signalrecieved, 0);
    checkOutput({tag, "/pulses"}, rises - r0, expPulses);
    checkOutput({tag, "/widths"}, widthErr - w0, 0);
    bus.candyflag = 1'b0;
    waitCycles(3);
  endtask

  // Run one command record and advance the reference view of last_state
  task automatic applyStimulus(input vec_t v, input string tag);
    armCommand(v.slot, v.amt, v.zeroFirst, v.expTrig, tag);
    if (v.cancel) cancelCommand(tag);
    else fireAndCheck(v.slot, v.expTrig, v.expPulses, v.expDir, v.disturb, tag);
    if (v.zeroFirst) modelLast = 3'd0;
    if (v.slot == 3'd0) modelLast = 3'd0;
    else if (v.slot != modelLast) modelLast = v.slot;
    if (v.cancel) modelLast = 3'd0;
  endtask

  // Main sequence: reset, directed table, random commands, then the hand-written corner cases
  initial begin
    vec_t v;
    int   found;
    bus.teststate   = 3'd0;
    bus.stateamount = 2'd0;
    bus.candyflag   = 1'b0;
    rst             = 1'b1;
    waitCycles(3);
    checkOutput("reset/step", bus.stepperstep, 0);
    checkOutput("reset/dir", bus.stepperdir, 0);
    checkOutput("reset/busy", bus.busy, 0);
    checkOutput("reset/ack", bus.signalrecieved, 0);
    checkOutput("reset/done", bus.done, 0);
    rst = 1'b0;
    waitCycles(2);

    //          slot  amt  zf cancel dist trig pulses dir
    vecs[0] = '{3'd2, 2'd1, 0, 0,    0,   1,   6,     1};
    vecs[1] = '{3'd5, 2'd3, 1, 0,    0,   1,   12,    0};
    vecs[2] = '{3'd3, 2'd0, 1, 1,    0,   1,   0,     1};
    vecs[3] = '{3'd1, 2'd2, 1, 0,    0,   1,   9,     1};
    vecs[4] = '{3'd1, 2'd0, 0, 0,    0,   0,   0,     1};
    vecs[5] = '{3'd1, 2'd0, 1, 0,    0,   1,   3,     1};
    vecs[6] = '{3'd6, 2'd1, 0, 0,    1,   1,   6,     0};
    vecs[7] = '{3'd7, 2'd3, 0, 0,    1,   1,   12,    0};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 12; i++) begin
      v.slot      = 3'($urandom_range(0, 7));
      v.amt       = 2'($urandom_range(0, 3));
      v.zeroFirst = ($urandom_range(0, 2) == 0);
      v.cancel    = ($urandom_range(0, 3) == 0);
      v.disturb   = ($urandom_range(0, 3) == 0);
      v.expTrig   = (v.slot != 3'd0) && (v.zeroFirst || v.slot != modelLast);
      v.expPulses = (v.expTrig && !v.cancel) ? (int'(v.amt) + 1) * STEPS_PER_UNIT : 0;
      v.expDir    = (v.slot <= 3'd3);
      applyStimulus(v, $sformatf("rnd%0d", i));
    end

    bus.teststate = 3'd0;
    waitCycles(4);
    bus.candyflag = 1'b1;
    waitCycles(4);
    armCommand(3'd4, 2'd0, 0, 1, "flagHigh");
    begin
      int r0;
      r0 = rises;
      waitCycles(20);
      checkOutput("flagHigh/noPulses", rises - r0, 0);
      checkOutput("flagHigh/stillArmed", bus.signalrecieved, 1);
    end
    bus.candyflag = 1'b0;
    waitCycles(4);
    fireAndCheck(3'd4, 1, STEPS_PER_UNIT, 0, 0, "flagHigh");

    armCommand(3'd6, 2'd1, 1, 1, "rstMid");
    bus.candyflag = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      waitCycles(1);
      if (bus.stepperstep === 1'b1) found = 1;
    end
    checkOutput("rstMid/stepSeen", found, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstMid/step", bus.stepperstep, 0);
    checkOutput("rstMid/busy", bus.busy, 0);
    checkOutput("rstMid/ack", bus.signalrecieved, 0);
    checkOutput("rstMid/done", bus.done, 0);
    @(negedge clk_x1);
    bus.teststate = 3'd0;
    bus.candyflag = 1'b0;
    waitCycles(2);
    rst = 1'b0;
    modelLast = 3'd0;
    waitCycles(4);
    checkOutput("rstMid/idleBusy", bus.busy, 0);
    checkOutput("rstMid/idleStep", bus.stepperstep, 0);

    v = '{3'd2, 2'd0, 1, 0, 0, 1, 3, 1};
    applyStimulus(v, "recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dispense_step_sequencer.md
# dispense_step_sequencer

Converts a dispense command from the Raspberry Pi (slot select, amount, go flag) into a bounded burst of stepper step/direction pulses, with an acknowledge back to the Pi. Sits upstream of the stepper driver pins (stepperstep/stepperdir) inside project_module. Sits downstream of the Pi GPIO inputs (teststate, stateamount, candyflag).

## Interface
- STEP_DIV, 3000: clock cycles per step half-period; 12 MHz gives 2 kHz steps.
- STEPS_PER_UNIT, 200: steps per dispensed unit.
- DIR_SETUP, 120: cycles stepperdir is held stable before the first step edge.
- clk_x1  in  1  12 MHz system clock.
- rst  in  1  reset, asynchronous, active-high.
- teststate  in  3  slot select from Pi; 0 means idle; asynchronous to clk_x1.
- stateamount  in  2  units to dispense, encoded amount-1 (0..3 gives 1..4 units); asynchronous.
- candyflag  in  1  dispense go request from Pi; asynchronous.
- signalrecieved  out  1  command-latched acknowledge to Pi.
- stepperstep  out  1  step pulse to driver.
- stepperdir  out  1  direction to driver.
- busy  out  1  high from latch until DONE.
- done  out  1  one-cycle pulse at end of burst.

## Operation
- All three Pi inputs pass through 2-flop synchronizers before use. candyflag rising edge is detected on the synchronized value.
- last_state register: cleared whenever synced teststate==0. A new command requires a nonzero teststate different from last_state.
- FSM states: IDLE, ARMED, SETUP, STEP_HI, STEP_LO, DONE.
- IDLE:
  - Trigger: synced teststate!=0 and !=last_state.
  - On trigger: latch slot=teststate, units=stateamount+1, last_state=teststate; go ARMED.
- ARMED:
  - signalrecieved=1 and busy=1.
  - Synced teststate==0 → cancel, go IDLE with no steps.
  - candyflag rising edge → steps_left=units*STEPS_PER_UNIT; stepperdir=1 if slot<=3, else 0; go SETUP.
- SETUP: hold stepperstep=0 for DIR_SETUP cycles, then go STEP_HI.
- STEP_HI: stepperstep=1 for STEP_DIV cycles, then go STEP_LO.
- STEP_LO:
  - stepperstep=0 for STEP_DIV cycles, then decrement steps_left.
  - If the decremented value is 0, go DONE; else go STEP_HI.
- DONE:
  - One cycle: done=1.
  - Next cycle: busy=0, signalrecieved=0, back to IDLE.
  - last_state is kept, so a held teststate does not retrigger.
- While in SETUP/STEP_HI/STEP_LO:
  - teststate and candyflag changes are ignored; a burst always completes.
  - latched slot and units are immune to input changes after latch.
- Widths:
  - steps_left is wide enough for 4*STEPS_PER_UNIT with no wrap; underflow is impossible because it is only decremented from a nonzero value.
  - Timer is wide enough for max(STEP_DIV, DIR_SETUP).
- stepperdir holds its last value in IDLE and ARMED.

## Timing
- Reset: all outputs 0, FSM=IDLE, last_state=0, synchronizers=0, counters=0. rst mid-burst aborts immediately: stepperstep=0 asynchronously.
- Input-change to internal use: 2-cycle synchronizer latency.
- IDLE→ARMED: the cycle after trigger detection. signalrecieved is registered and rises with the ARMED state.
- candyflag edge detection: 1 cycle after it is synchronized. The cycle after detection enters SETUP with stepperdir updated.
- First stepperstep rise: DIR_SETUP cycles after entering SETUP.
- Step period: exactly 2*STEP_DIV cycles, 50% duty.
- Burst length from SETUP entry to DONE: DIR_SETUP + units*STEPS_PER_UNIT*2*STEP_DIV cycles.
- Simultaneous candyflag edge and teststate==0 in ARMED: cancel wins.
- candyflag high already on entry to ARMED: not an edge; a fresh rise is required.

## Test plan
Use STEP_DIV=2, STEPS_PER_UNIT=3, DIR_SETUP=4.
- rst pulse mid-STEP_HI → stepperstep, busy, signalrecieved drop to 0 immediately; FSM idle.
- teststate=3'b010, stateamount=2'b01, then candyflag rise → signalrecieved=1; stepperdir=1; 6 step pulses, each 2 cycles high and 2 low; first rise 4 cycles after SETUP; single done pulse; 28 cycles SETUP→DONE.
- teststate=3'b101, stateamount=2'b11, candyflag rise → stepperdir=0; exactly 12 pulses.
- teststate=3'b011, then teststate=0 before candyflag → no step pulses; signalrecieved returns to 0; done never pulses.
- teststate held at 3'b001 after DONE with a second candyflag rise → no new burst. Then teststate 0→3'b001 plus candyflag → new burst of the latched amount.
- Mid-burst change of stateamount/teststate and candyflag toggles → pulse count equals the originally latched value.
